fetch_controller: RTL and testbench
===================================

FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter NB_INSTRUCTION, default 16, instruction word width.
REQ-002 SHALL have parameter NB_ADDR, default 10, ROM address width; ROM_DEPTH = 2**NB_ADDR.
REQ-003 SHALL have parameter NB_OPCODE, default 5, opcode field width, taken from instruction MSBs.
REQ-004 SHALL have parameter HALT_OPCODE, default 0, opcode value that stops fetching.
REQ-005 SHALL have parameter NB_COUNT, default 32, fetch counter width.
REQ-006 SHALL have port i_clock, input, 1, single clock; all state changes on its rising edge.
REQ-007 SHALL have port i_reset, input, 1, asynchronous, active-high reset.
REQ-008 SHALL have port i_run, input, 1, start or resume continuous fetch.
REQ-009 SHALL have port i_pause, input, 1, suspend continuous fetch.
REQ-010 SHALL have port i_step, input, 1, fetch exactly one instruction while paused.
REQ-011 SHALL have port i_clear, input, 1, synchronous restart to IDLE with PC 0.
REQ-012 SHALL have port i_jump_valid, input, 1, load i_jump_addr as next PC.
REQ-013 SHALL have port i_jump_addr, input, NB_ADDR, jump target.
REQ-014 SHALL have port i_rom_data, input, NB_INSTRUCTION, combinational ROM read data for o_rom_addr.
REQ-015 SHALL have port o_rom_addr, output, NB_ADDR, ROM read address, equal to the PC.
REQ-016 SHALL have port o_instruction, output, NB_INSTRUCTION, registered fetched instruction.
REQ-017 SHALL have port o_instr_valid, output, 1, one-cycle pulse per fetched instruction.
REQ-018 SHALL have port o_halted, output, 1, high while in HALTED.
REQ-019 SHALL have port o_fetch_count, output, NB_COUNT, instructions issued since reset or clear.

Function
REQ-020 SHALL implement the states IDLE, RUN, PAUSE and HALTED.
REQ-021 A fetch cycle SHALL register i_rom_data into o_instruction, assert o_instr_valid on the following cycle, and increment o_fetch_count; latency from address to valid is 1 cycle.
REQ-022 IDLE: no fetch; i_run -> RUN; i_step -> PAUSE after one fetch at the current PC.
REQ-023 RUN: every cycle is a fetch cycle; i_pause -> PAUSE, with no fetch in that cycle; i_pause wins over simultaneous i_run.
REQ-024 PAUSE: i_step performs one fetch and remains in PAUSE; i_run -> RUN; i_run wins over simultaneous i_step, and no fetch occurs in that cycle.
REQ-025 Next PC after a fetch: hold if the fetched opcode equals HALT_OPCODE; otherwise i_jump_addr if i_jump_valid; otherwise PC+1.
REQ-026 Halt detection SHALL take priority over a simultaneous jump.
REQ-027 In a non-fetch cycle outside HALTED, i_jump_valid SHALL load the PC with i_jump_addr.
REQ-028 PC increment from ROM_DEPTH-1 SHALL wrap to 0 without a flag.
REQ-029 A fetched HALT_OPCODE instruction SHALL be issued (valid pulse, counted) and SHALL move the FSM to HALTED.
REQ-030 HALTED SHALL ignore i_run, i_step, i_pause and i_jump_valid and SHALL leave o_halted = 1.
REQ-031 i_clear in any state SHALL force IDLE with PC 0, o_fetch_count 0 and o_instr_valid 0; i_clear overrides all other inputs.
REQ-032 o_fetch_count SHALL wrap modulo 2**NB_COUNT.
REQ-033 o_rom_addr SHALL be driven directly from the PC register with no combinational path from inputs.

Reset
REQ-034 i_reset high SHALL immediately force IDLE, PC 0, o_instruction 0, o_instr_valid 0, o_halted 0 and o_fetch_count 0, including mid-RUN.
REQ-035 The first fetch after reset release SHALL require an explicit i_run or i_step.

Structure
REQ-036 A shared package SHALL hold the state encoding constants and the opcode field position/width helpers.
REQ-037 A single sub-module program_counter (PC register, increment, jump and hold muxing) SHALL be instantiated; the FSM and fetch counter SHALL remain in fetch_controller.

Verification
REQ-038 Reset, then i_run, with ROM words 0..3 nonzero and word 4 opcode 0 -> valid pulses for addresses 0..4, then o_halted = 1, PC 4, count 5.
REQ-039 RUN, i_pause at PC 2, then three i_step pulses -> exactly 3 valid pulses for addresses 2, 3, 4; PC 5; state PAUSE.
REQ-040 Fetch at PC 7 with i_jump_valid = 1 and i_jump_addr = 0x3F0 -> instruction 7 issued, next o_rom_addr = 0x3F0; with word 7 set to HALT_OPCODE instead -> PC holds at 7.
REQ-041 PC 0x3FF with a non-halt word in RUN -> next o_rom_addr = 0x000.
REQ-042 In HALTED: i_run and i_jump_valid are ignored; i_clear -> IDLE, PC 0, count 0, o_halted 0.
REQ-043 i_reset asserted mid-RUN between clock edges -> outputs reach reset values before the next edge; no valid pulse follows.

Source files
------------

// File: rtl/fetch_controller_pkg.sv
// Shared definitions for the fetch controller slice.
//   fetch_state_t : FSM state encoding (IDLE, RUN, PAUSE, HALTED)
//   opcode_lsb()  : bit position of the opcode field, which occupies the
//                   instruction MSBs
package fetch_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSE  = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_t;

  function automatic int unsigned opcode_lsb(input int unsigned nb_instruction,
                                             input int unsigned nb_opcode);
    return nb_instruction - nb_opcode;
  endfunction

endpackage

// File: rtl/fetch_controller_program_counter.sv
// Program counter register with increment, jump and hold muxing.
//   i_clock, i_reset : clock, async active-high reset
//   i_clear          : synchronous return to PC 0
//   i_fetch          : current cycle fetches the instruction at o_pc
//   i_halt_hit       : fetched opcode is the halt opcode (PC holds)
//   i_jump_load      : non-fetch cycle jump request (already qualified)
//   i_jump_valid     : jump request, used during fetch cycles
//   i_jump_addr      : jump target
//   o_pc             : PC register, drives the ROM address directly
module program_counter #(
  parameter int unsigned NB_ADDR = 10
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_clear,
  input  logic               i_fetch,
  input  logic               i_halt_hit,
  input  logic               i_jump_load,
  input  logic               i_jump_valid,
  input  logic [NB_ADDR-1:0] i_jump_addr,
  output logic [NB_ADDR-1:0] o_pc
);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_pc <= '0;
    end else if (i_clear) begin
      o_pc <= '0;
    end else if (i_fetch) begin
      // Halt beats a simultaneous jump; increment wraps silently.
      if (i_halt_hit)        o_pc <= o_pc;
      else if (i_jump_valid) o_pc <= i_jump_addr;
      else                   o_pc <= o_pc + NB_ADDR'(1);
    end else if (i_jump_load) begin
      o_pc <= i_jump_addr;
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: run/pause/step FSM with halt detection,
// registered instruction output, valid pulse and fetch counter.
//   i_clock, i_reset          : clock, async active-high reset
//   i_run, i_pause, i_step    : fetch control
//   i_clear                   : synchronous restart (IDLE, PC 0, count 0)
//   i_jump_valid, i_jump_addr : next-PC override
//   i_rom_data                : combinational ROM data for o_rom_addr
//   o_rom_addr                : PC register
//   o_instruction             : last fetched instruction
//   o_instr_valid             : one-cycle pulse per fetched instruction
//   o_halted                  : high while halted
//   o_fetch_count             : instructions issued since reset/clear
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter int unsigned NB_INSTRUCTION = 16,
  parameter int unsigned NB_ADDR        = 10,
  parameter int unsigned NB_OPCODE      = 5,
  parameter int unsigned HALT_OPCODE    = 0,
  parameter int unsigned NB_COUNT       = 32
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_run,
  input  logic                      i_pause,
  input  logic                      i_step,
  input  logic                      i_clear,
  input  logic                      i_jump_valid,
  input  logic [NB_ADDR-1:0]        i_jump_addr,
  input  logic [NB_INSTRUCTION-1:0] i_rom_data,
  output logic [NB_ADDR-1:0]        o_rom_addr,
  output logic [NB_INSTRUCTION-1:0] o_instruction,
  output logic                      o_instr_valid,
  output logic                      o_halted,
  output logic [NB_COUNT-1:0]       o_fetch_count
);

  localparam int unsigned          OPCODE_LSB = opcode_lsb(NB_INSTRUCTION, NB_OPCODE);
  localparam logic [NB_OPCODE-1:0] HALT_OP    = NB_OPCODE'(HALT_OPCODE);

  fetch_state_t         state;
  fetch_state_t         state_next;
  logic                 fetch;
  logic                 halt_hit;
  logic                 jump_load;
  logic [NB_OPCODE-1:0] opcode;

  assign opcode = i_rom_data[OPCODE_LSB +: NB_OPCODE];

  // Fetch qualification: run beats step in IDLE/PAUSE, pause beats run in RUN.
  always_comb begin
    fetch = 1'b0;
    if (!i_clear) begin
      case (state)
        ST_IDLE:  fetch = i_step && !i_run;
        ST_RUN:   fetch = !i_pause;
        ST_PAUSE: fetch = i_step && !i_run;
        default:  fetch = 1'b0;
      endcase
    end
  end

  assign halt_hit  = fetch && (opcode == HALT_OP);
  assign jump_load = !i_clear && !fetch && (state != ST_HALTED) && i_jump_valid;

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (i_run)       state_next = ST_RUN;
        else if (i_step) state_next = halt_hit ? ST_HALTED : ST_PAUSE;
      end
      ST_RUN: begin
        if (i_pause)       state_next = ST_PAUSE;
        else if (halt_hit) state_next = ST_HALTED;
      end
      ST_PAUSE: begin
        if (i_run)         state_next = ST_RUN;
        else if (halt_hit) state_next = ST_HALTED;
      end
      default: state_next = ST_HALTED;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state         <= ST_IDLE;
      o_instruction <= '0;
      o_instr_valid <= 1'b0;
      o_halted      <= 1'b0;
      o_fetch_count <= '0;
    end else if (i_clear) begin
      state         <= ST_IDLE;
      o_instr_valid <= 1'b0;
      o_halted      <= 1'b0;
      o_fetch_count <= '0;
    end else begin
      state         <= state_next;
      o_halted      <= (state_next == ST_HALTED);
      o_instr_valid <= fetch;
      if (fetch) begin
        o_instruction <= i_rom_data;
        o_fetch_count <= o_fetch_count + NB_COUNT'(1);
      end
    end
  end

  program_counter #(
    .NB_ADDR (NB_ADDR)
  ) u_program_counter (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_clear      (i_clear),
    .i_fetch      (fetch),
    .i_halt_hit   (halt_hit),
    .i_jump_load  (jump_load),
    .i_jump_valid (i_jump_valid),
    .i_jump_addr  (i_jump_addr),
    .o_pc         (o_rom_addr)
  );

endmodule

// File: tb/tb_fetch_controller.sv
module tb_fetch_controller;

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_HALT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0, pause = 1'b0, step = 1'b0, clr = 1'b0, jv = 1'b0;
  logic [9:0]  ja = '0;
  logic [15:0] rom_data;
  logic [9:0]  rom_addr;
  logic [15:0] instr;
  logic        valid, halted;
  logic [31:0] fcount;

  logic [15:0] rom [0:1023];

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // behavioural reference state
  int          m_mode  = M_IDLE;
  logic [9:0]  m_pc    = '0;
  logic [31:0] m_cnt   = '0;
  bit          m_valid = 1'b0;
  logic [15:0] m_instr = '0;
  logic [15:0] m_word;
  bit          m_go;

  int          npulse;
  logic [15:0] pulses [0:15];

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  fetch_controller #(
    .NB_INSTRUCTION (16),
    .NB_ADDR        (10),
    .NB_OPCODE      (5),
    .HALT_OPCODE    (0),
    .NB_COUNT       (32)
  ) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_run         (run),
    .i_pause       (pause),
    .i_step        (step),
    .i_clear       (clr),
    .i_jump_valid  (jv),
    .i_jump_addr   (ja),
    .i_rom_data    (rom_data),
    .o_rom_addr    (rom_addr),
    .o_instruction (instr),
    .o_instr_valid (valid),
    .o_halted      (halted),
    .o_fetch_count (fcount)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one step per rising edge, from the rules of operation.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = M_IDLE; m_pc = '0; m_cnt = '0; m_valid = 1'b0; m_instr = '0;
    end else if (clr) begin
      m_mode = M_IDLE; m_pc = '0; m_cnt = '0; m_valid = 1'b0;
    end else begin
      m_word = rom[m_pc];
      m_go   = 1'b0;
      if (m_mode == M_IDLE) begin
        if (run) m_mode = M_RUN;
        else if (step) begin m_go = 1'b1; m_mode = M_PAUSE; end
      end else if (m_mode == M_RUN) begin
        if (pause) m_mode = M_PAUSE;
        else m_go = 1'b1;
      end else if (m_mode == M_PAUSE) begin
        if (run) m_mode = M_RUN;
        else if (step) m_go = 1'b1;
      end
      m_valid = m_go;
      if (m_go) begin
        m_instr = m_word;
        m_cnt   = m_cnt + 1;
        if (m_word[15:11] == 5'd0) m_mode = M_HALT;
        else if (jv)               m_pc = ja;
        else                       m_pc = m_pc + 10'd1;
      end else if (m_mode != M_HALT && jv) begin
        m_pc = ja;
      end
    end
  end

  // Compare process: outputs against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model rom_addr", {22'd0, rom_addr}, {22'd0, m_pc});
      chk("model valid", {31'd0, valid}, {31'd0, m_valid});
      chk("model halted", {31'd0, halted}, {31'd0, (m_mode == M_HALT)});
      chk("model count", fcount, m_cnt);
      chk("model instruction", {16'd0, instr}, {16'd0, m_instr});
    end
  end

  task automatic tick(input logic r, input logic p, input logic s, input logic c,
                      input logic j, input logic [9:0] a);
    run = r; pause = p; step = s; clr = c; jv = j; ja = a;
    @(negedge clk);
    run = 1'b0; pause = 1'b0; step = 1'b0; clr = 1'b0; jv = 1'b0;
  endtask

  task automatic idle_collect(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      tick(0, 0, 0, 0, 0, '0);
      if (valid) begin
        if (npulse < 16) pulses[npulse] = instr;
        npulse++;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 16'h8000 | 16'(i);

    // reset and idle after release
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset rom_addr", {22'd0, rom_addr}, 32'd0);
    chk("reset valid", {31'd0, valid}, 32'd0);
    chk("reset halted", {31'd0, halted}, 32'd0);
    chk("reset count", fcount, 32'd0);
    chk("reset instruction", {16'd0, instr}, 32'd0);
    chk_en = 1'b1;
    repeat (3) tick(0, 0, 0, 0, 0, '0);
    chk("no fetch without run", fcount, 32'd0);

    // run into a halt word at address 4
    rom[4] = 16'h0004;
    npulse = 0;
    tick(1, 0, 0, 0, 0, '0);
    idle_collect(9);
    chk("halt run pulses", npulse, 32'd5);
    for (int k = 0; k < 5; k++) chk("halt run pulse addr", {22'd0, pulses[k][9:0]}, k);
    chk("halt run halted", {31'd0, halted}, 32'd1);
    chk("halt run pc", {22'd0, rom_addr}, 32'd4);
    chk("halt run count", fcount, 32'd5);

    // halted ignores run and jump; clear overrides everything
    tick(1, 0, 1, 0, 1, 10'h100);
    chk("halted ignores pc", {22'd0, rom_addr}, 32'd4);
    chk("halted ignores halted", {31'd0, halted}, 32'd1);
    chk("halted ignores valid", {31'd0, valid}, 32'd0);
    tick(1, 1, 1, 1, 1, 10'h055);
    chk("clear pc", {22'd0, rom_addr}, 32'd0);
    chk("clear count", fcount, 32'd0);
    chk("clear halted", {31'd0, halted}, 32'd0);
    chk("clear valid", {31'd0, valid}, 32'd0);
    rom[4] = 16'h8004;

    // pause at PC 2, then three steps
    tick(1, 0, 0, 0, 0, '0);
    for (int k = 0; k < 20 && rom_addr != 10'd2; k++) tick(0, 0, 0, 0, 0, '0);
    chk("reach pc 2", {22'd0, rom_addr}, 32'd2);
    tick(0, 1, 0, 0, 0, '0);
    chk("pause no fetch", {31'd0, valid}, 32'd0);
    npulse = 0;
    for (int k = 0; k < 3; k++) begin
      tick(0, 0, 1, 0, 0, '0);
      if (valid) begin
        if (npulse < 16) pulses[npulse] = instr;
        npulse++;
      end
      idle_collect(1);
    end
    idle_collect(2);
    chk("step pulses", npulse, 32'd3);
    for (int k = 0; k < 3; k++) chk("step pulse addr", {22'd0, pulses[k][9:0]}, k + 2);
    chk("step pc", {22'd0, rom_addr}, 32'd5);
    chk("step halted", {31'd0, halted}, 32'd0);

    // jump during a fetch at PC 7, then halt beats jump
    tick(0, 0, 0, 1, 0, '0);
    tick(0, 0, 0, 0, 1, 10'd7);
    chk("idle jump pc", {22'd0, rom_addr}, 32'd7);
    tick(0, 0, 1, 0, 1, 10'h3F0);
    chk("fetch jump valid", {31'd0, valid}, 32'd1);
    chk("fetch jump instr", {16'd0, instr}, 32'h8007);
    chk("fetch jump pc", {22'd0, rom_addr}, 32'h3F0);
    tick(0, 0, 0, 1, 0, '0);
    rom[7] = 16'h0007;
    tick(0, 0, 0, 0, 1, 10'd7);
    tick(0, 0, 1, 0, 1, 10'h3F0);
    chk("halt over jump pc", {22'd0, rom_addr}, 32'd7);
    chk("halt over jump halted", {31'd0, halted}, 32'd1);
    chk("halt over jump valid", {31'd0, valid}, 32'd1);
    rom[7] = 16'h8007;

    // PC wrap from the top of the ROM
    tick(0, 0, 0, 1, 0, '0);
    tick(0, 0, 0, 0, 1, 10'h3FF);
    tick(1, 0, 0, 0, 0, '0);
    tick(0, 0, 0, 0, 0, '0);
    chk("wrap instr", {16'd0, instr}, 32'h83FF);
    chk("wrap pc", {22'd0, rom_addr}, 32'd0);
    tick(0, 1, 0, 0, 0, '0);

    // async reset between edges while running
    tick(0, 0, 0, 1, 0, '0);
    tick(1, 0, 0, 0, 0, '0);
    repeat (4) tick(0, 0, 0, 0, 0, '0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async rst pc", {22'd0, rom_addr}, 32'd0);
    chk("async rst valid", {31'd0, valid}, 32'd0);
    chk("async rst count", fcount, 32'd0);
    chk("async rst instr", {16'd0, instr}, 32'd0);
    chk("async rst halted", {31'd0, halted}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    npulse = 0;
    idle_collect(3);
    chk("no pulse after rst", npulse, 32'd0);

    // randomized traffic against the model
    for (int i = 0; i < 1024; i++) begin
      rom[i] = 16'($urandom);
      if ($urandom_range(15) == 0) rom[i][15:11] = 5'd0;
      else if (rom[i][15:11] == 5'd0) rom[i][15] = 1'b1;
    end
    for (int k = 0; k < 4000; k++) begin
      tick(($urandom % 4) == 0, ($urandom % 8) == 0, ($urandom % 3) == 0,
           ($urandom % 50) == 0, ($urandom % 5) == 0, 10'($urandom));
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
